// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a synchronised PLL lock, lets the clocks settle,
// then releases a bank of active-low resets one at a time with a fixed gap.
// Losing lock at any point after WAIT_LOCK drops every reset and counts the
// event; a soft request with lock held restarts from the settle delay.
module reset_sequencer #(
  parameter int NUM_OUT      = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DELAY_CYCLES = 100,
  parameter int STAGE_GAP    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               ready,
  output logic [1:0]         state,
  output logic [7:0]         lock_lost_cnt
);

  // One shared counter serves both the settle delay and the stage gaps, so
  // it is sized for the larger of the two terminal values.
  localparam int MAX_CNT = (DELAY_CYCLES > STAGE_GAP) ? DELAY_CYCLES : STAGE_GAP;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST  = IDX_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    DELAY     = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 fsm_state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       stage_idx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign state  = fsm_state;

  // Bring the asynchronous lock indication into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Sequencing FSM: lock loss beats soft abort, which beats normal progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_state     <= WAIT_LOCK;
      cnt           <= '0;
      stage_idx     <= '0;
      rst_out_n     <= '0;
      ready         <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else if (fsm_state == WAIT_LOCK) begin
      if (lock_s) begin
        fsm_state <= DELAY;
        cnt       <= '0;
        stage_idx <= '0;
      end
    end else if (!lock_s) begin
      fsm_state <= WAIT_LOCK;
      cnt       <= '0;
      stage_idx <= '0;
      rst_out_n <= '0;
      ready     <= 1'b0;
      if (lock_lost_cnt != 8'hFF) begin
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
      end
    end else if (sw_rst_req) begin
      fsm_state <= DELAY;
      cnt       <= '0;
      stage_idx <= '0;
      rst_out_n <= '0;
      ready     <= 1'b0;
    end else begin
      case (fsm_state)
        DELAY: begin
          if (cnt == DELAY_LAST) begin
            rst_out_n[0] <= 1'b1;
            cnt          <= '0;
            if (NUM_OUT == 1) begin
              fsm_state <= RUN;
              ready     <= 1'b1;
            end else begin
              fsm_state <= RELEASE;
              stage_idx <= IDX_FIRST;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_out_n[stage_idx] <= 1'b1;
            cnt                  <= '0;
            if (stage_idx == IDX_LAST) begin
              fsm_state <= RUN;
              ready     <= 1'b1;
            end else begin
              stage_idx <= stage_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at its default parameters.
// Each phase drives the inputs for a fixed number of edges and compares
// the registered outputs 1 ns after the edge against hand-worked values.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic [3:0] rst_out_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_lost_cnt;

  int checks = 0;
  int errors = 0;

  // Release pattern after bits 0..3 have gone high, in order.
  localparam logic [3:0] REL_PAT [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  reset_sequencer #(
    .NUM_OUT      (4),
    .SYNC_STAGES  (2),
    .DELAY_CYCLES (100),
    .STAGE_GAP    (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .rst_out_n     (rst_out_n),
    .ready         (ready),
    .state         (state),
    .lock_lost_cnt (lock_lost_cnt)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Drive all inputs, then advance the given number of rising edges.
  task automatic applyStimulus(input logic rn, input logic pl, input logic sw,
                               input int cycles);
    reset_n    = rn;
    pll_locked = pl;
    sw_rst_req = sw;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single comparison point: counts and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Starts just after DELAY entry: bit 0 rises exactly 100 edges later.
  task automatic delayPhase(input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, 99);
    checkOutput({tag, "_d99_rst"},   32'(rst_out_n), 32'h0);
    checkOutput({tag, "_d99_state"}, 32'(state),     32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput({tag, "_d100_rst"},   32'(rst_out_n), 32'(REL_PAT[0]));
    checkOutput({tag, "_d100_state"}, 32'(state),     32'd2);
    checkOutput({tag, "_d100_ready"}, 32'(ready),     32'd0);
  endtask

  // Starts just after bit 0 rises: each further bit 16 edges after the last.
  task automatic releasePhase(input string tag, input int last_bit);
    for (int k = 1; k <= last_bit; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 15);
      checkOutput($sformatf("%s_b%0d_early", tag, k), 32'(rst_out_n),
                  32'(REL_PAT[k-1]));
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      checkOutput($sformatf("%s_b%0d_rst", tag, k), 32'(rst_out_n),
                  32'(REL_PAT[k]));
      checkOutput($sformatf("%s_b%0d_state", tag, k), 32'(state),
                  (k == 3) ? 32'd3 : 32'd2);
      checkOutput($sformatf("%s_b%0d_ready", tag, k), 32'(ready),
                  (k == 3) ? 32'd1 : 32'd0);
    end
  endtask

  // From WAIT_LOCK with lock just asserted: E0 sample, E1 lock_s, E2 DELAY.
  task automatic powerUp(input string tag, input int last_bit);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput({tag, "_e1_state"}, 32'(state), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput({tag, "_e2_state"}, 32'(state),     32'd1);
    checkOutput({tag, "_e2_rst"},   32'(rst_out_n), 32'h0);
    delayPhase(tag);
    releasePhase(tag, last_bit);
  endtask

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario list.
  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    checkOutput("rst_rst_out", 32'(rst_out_n),     32'h0);
    checkOutput("rst_ready",   32'(ready),         32'd0);
    checkOutput("rst_state",   32'(state),         32'd0);
    checkOutput("rst_lost",    32'(lock_lost_cnt), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    checkOutput("wait_sw_ignored", 32'(state), 32'd0);

    pll_locked = 1'b1;
    #3;
    pll_locked = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    checkOutput("glitch_wait_state", 32'(state), 32'd0);

    powerUp("pu", 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("loss_a0_state", 32'(state),     32'd2);
    checkOutput("loss_a0_rst",   32'(rst_out_n), 32'h3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("loss_a1_state", 32'(state), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("loss_a2_state", 32'(state),         32'd0);
    checkOutput("loss_a2_rst",   32'(rst_out_n),     32'h0);
    checkOutput("loss_a2_ready", 32'(ready),         32'd0);
    checkOutput("loss_a2_lost",  32'(lock_lost_cnt), 32'd1);

    powerUp("relock", 3);

    pll_locked = 1'b0;
    #3;
    pll_locked = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    checkOutput("glitch_run_state", 32'(state),         32'd3);
    checkOutput("glitch_run_rst",   32'(rst_out_n),     32'hF);
    checkOutput("glitch_run_lost",  32'(lock_lost_cnt), 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("soft_state", 32'(state),     32'd1);
    checkOutput("soft_rst",   32'(rst_out_n), 32'h0);
    checkOutput("soft_ready", 32'(ready),     32'd0);
    delayPhase("soft");
    checkOutput("soft_lost", 32'(lock_lost_cnt), 32'd1);
    releasePhase("soft", 3);

    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("both_pre_state", 32'(state), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("both_state", 32'(state),         32'd0);
    checkOutput("both_rst",   32'(rst_out_n),     32'h0);
    checkOutput("both_lost",  32'(lock_lost_cnt), 32'd2);

    powerUp("pre_rst", 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("rstall_pre_state", 32'(state), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("rstall_state", 32'(state),         32'd0);
    checkOutput("rstall_rst",   32'(rst_out_n),     32'h0);
    checkOutput("rstall_ready", 32'(ready),         32'd0);
    checkOutput("rstall_lost",  32'(lock_lost_cnt), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    powerUp("mid", 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("midrst_state", 32'(state),     32'd0);
    checkOutput("midrst_rst",   32'(rst_out_n), 32'h0);
    powerUp("restart", 3);

    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    for (int i = 1; i <= 260; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 3);
      applyStimulus(1'b1, 1'b0, 1'b0, 3);
      if (i == 1) checkOutput("sat_1", 32'(lock_lost_cnt), 32'd1);
      if (i == 254) checkOutput("sat_254", 32'(lock_lost_cnt), 32'd254);
      if (i == 255) checkOutput("sat_255", 32'(lock_lost_cnt), 32'd255);
    end
    checkOutput("sat_260",       32'(lock_lost_cnt), 32'd255);
    checkOutput("sat_260_state", 32'(state),         32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
